// File: rtl/decode_pkg.sv
// Shared constants for the phase-sequenced decoder: ALU op codes,
// instruction classes, the Q1..Q4 phase enum and the byte-op sub-op map.
package decode_pkg;

  localparam logic [3:0] OP_MOVF = 4'd0;
  localparam logic [3:0] OP_NOP  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_RLF  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;
  localparam logic [3:0] OP_IOR  = 4'd10;
  localparam logic [3:0] OP_SWAP = 4'd11;
  localparam logic [3:0] OP_COM  = 4'd12;
  localparam logic [3:0] OP_BSF  = 4'd13;
  localparam logic [3:0] OP_BCF  = 4'd14;
  localparam logic [3:0] OP_RRF  = 4'd15;

  localparam logic [1:0] CLS_BYTE = 2'b00;
  localparam logic [1:0] CLS_BIT  = 2'b01;
  localparam logic [1:0] CLS_CTRL = 2'b10;
  localparam logic [1:0] CLS_LIT  = 2'b11;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_e;

  // Byte-op sub-op to ALU op. DECFSZ/INCFSZ share DEC/INC; the skip test
  // is layered on top by the sequencer.
  function automatic logic [3:0] byte_op(input logic [3:0] sub);
    logic [3:0] op;
    op = OP_NOP;
    case (sub)
      4'b0111: op = OP_ADD;
      4'b0101: op = OP_AND;
      4'b0001: op = OP_CLR;
      4'b1001: op = OP_COM;
      4'b0011: op = OP_DEC;
      4'b1011: op = OP_DEC;
      4'b1010: op = OP_INC;
      4'b1111: op = OP_INC;
      4'b0100: op = OP_IOR;
      4'b1000: op = OP_MOVF;
      4'b0000: op = OP_NOP;
      4'b1101: op = OP_RLF;
      4'b1100: op = OP_RRF;
      4'b0010: op = OP_SUB;
      4'b1110: op = OP_SWAP;
      4'b0110: op = OP_XOR;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational field decode of one instruction word. No state; the
// sequencer decides when these fields are captured.
module decode_comb
  import decode_pkg::*;
#(
  parameter int INST_W   = 8,
  parameter int BIT_W    = 3,
  parameter int ALU_OP_W = 4
) (
  input  logic [INST_W-1:0]   inst_reg,
  output logic [ALU_OP_W-1:0] op,
  output logic                d,
  output logic                switch_a_m,
  output logic                act_ram,
  output logic                wr,
  output logic                is_bit,
  output logic [BIT_W-1:0]    bit_number,
  output logic                skip_zero,
  output logic                skip_clr,
  output logic                skip_set,
  output logic                ctrl,
  output logic                call,
  output logic [INST_W-4:0]   pc_target,
  output logic                illegal
);

  logic [1:0] cls;
  logic [3:0] sub;

  assign cls        = inst_reg[INST_W-1 -: 2];
  assign sub        = inst_reg[INST_W-3 -: 4];
  assign bit_number = inst_reg[BIT_W:1];
  assign pc_target  = inst_reg[INST_W-4:0];

  // Class / sub-op decode into ALU op, operand routing and behaviour flags
  always_comb begin
    op         = ALU_OP_W'(OP_NOP);
    d          = 1'b0;
    switch_a_m = 1'b0;
    act_ram    = 1'b0;
    wr         = 1'b0;
    is_bit     = 1'b0;
    skip_zero  = 1'b0;
    skip_clr   = 1'b0;
    skip_set   = 1'b0;
    ctrl       = 1'b0;
    call       = 1'b0;
    illegal    = 1'b0;
    case (cls)
      CLS_BYTE: begin
        act_ram    = 1'b1;
        d          = inst_reg[1];
        switch_a_m = 1'b1;
        wr         = 1'b1;
        op         = ALU_OP_W'(byte_op(sub));
        skip_zero  = (sub == 4'b1011) || (sub == 4'b1111);
      end
      CLS_BIT: begin
        act_ram    = 1'b1;
        d          = 1'b1;
        switch_a_m = 1'b1;
        is_bit     = 1'b1;
        case (sub[3:2])
          2'b00:   begin op = ALU_OP_W'(OP_BCF); wr = 1'b1; end
          2'b01:   begin op = ALU_OP_W'(OP_BSF); wr = 1'b1; end
          2'b10:   skip_clr = 1'b1;
          default: skip_set = 1'b1;
        endcase
      end
      CLS_LIT: begin
        // Unlisted literal encodings (01xx, and the unused 1011) are
        // treated as illegal: NOP with no write.
        casez (sub)
          4'b00??: begin op = ALU_OP_W'(OP_MOVF); wr = 1'b1; end
          4'b1000: begin op = ALU_OP_W'(OP_IOR);  wr = 1'b1; end
          4'b1001: begin op = ALU_OP_W'(OP_AND);  wr = 1'b1; end
          4'b1010: begin op = ALU_OP_W'(OP_XOR);  wr = 1'b1; end
          4'b110?: begin op = ALU_OP_W'(OP_SUB);  wr = 1'b1; end
          4'b111?: begin op = ALU_OP_W'(OP_ADD);  wr = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        ctrl = 1'b1;
        call = ~inst_reg[INST_W-3];
      end
    endcase
  end

endmodule

// File: rtl/decode_seq.sv
// Phase-sequenced decoder: an internal Q1..Q4 counter on one clock, a
// valid/ready intake in Q4, registered decode fields for the following
// instruction cycle, skip/jump squash of the next accepted instruction.
// Optional: DECODE_ILLEGAL_TRAP_EN enables the sticky illegal-opcode flag.
// INST_W must be >= 8.
module decode_seq
  import decode_pkg::*;
#(
  parameter int INST_W   = 8,
  parameter int BIT_W    = 3,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [INST_W-1:0]   inst_reg,
  input  logic                alu_zero,
  input  logic                bit_val,
  output logic [1:0]          phase,
  output logic                d,
  output logic                switch_a_m,
  output logic                act_ram,
  output logic                write_en,
  output logic [BIT_W-1:0]    bit_number,
  output logic [ALU_OP_W-1:0] inst,
  output logic                skip_taken,
  output logic                pc_load,
  output logic                push_en,
  output logic [INST_W-4:0]   pc_target,
  output logic                illegal
);

  // decoded fields of the word currently on inst_reg
  logic [ALU_OP_W-1:0] dc_op;
  logic                dc_d, dc_sam, dc_act, dc_wr, dc_is_bit;
  logic [BIT_W-1:0]    dc_bit;
  logic                dc_skz, dc_skc, dc_sks, dc_ctrl, dc_call, dc_illegal;
  logic [INST_W-4:0]   dc_tgt;

  decode_comb #(
    .INST_W  (INST_W),
    .BIT_W   (BIT_W),
    .ALU_OP_W(ALU_OP_W)
  ) u_decode_comb (
    .inst_reg  (inst_reg),
    .op        (dc_op),
    .d         (dc_d),
    .switch_a_m(dc_sam),
    .act_ram   (dc_act),
    .wr        (dc_wr),
    .is_bit    (dc_is_bit),
    .bit_number(dc_bit),
    .skip_zero (dc_skz),
    .skip_clr  (dc_skc),
    .skip_set  (dc_sks),
    .ctrl      (dc_ctrl),
    .call      (dc_call),
    .pc_target (dc_tgt),
    .illegal   (dc_illegal)
  );

  phase_e              phase_q, phase_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic                d_q, d_d, sam_q, sam_d, act_q, act_d, wr_q, wr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                skz_q, skz_d, skc_q, skc_d, sks_q, sks_d;
  logic                ctrl_q, ctrl_d, call_q, call_d;
  logic [INST_W-4:0]   tgt_q, tgt_d;

  logic in_q4, skip_cond, take;

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= Q1;
    else        phase_q <= phase_d;
  end

  // Phase next-state: free-running Q1->Q2->Q3->Q4->Q1
  always_comb begin
    phase_d = Q1;
    case (phase_q)
      Q1:      phase_d = Q2;
      Q2:      phase_d = Q3;
      Q3:      phase_d = Q4;
      default: phase_d = Q1;
    endcase
  end

  // Phase-derived strobes: ready, write window, Q4 pulses and skip test
  always_comb begin
    in_q4      = (phase_q == Q4);
    inst_ready = in_q4;
    write_en   = wr_q && ((phase_q == Q3) || in_q4);
    pc_load    = in_q4 && ctrl_q;
    push_en    = in_q4 && ctrl_q && call_q;
    skip_cond  = in_q4 && ((skz_q && alu_zero) || (skc_q && !bit_val) ||
                           (sks_q && bit_val));
    // a jump always wins over a skip
    skip_taken = skip_cond && !pc_load;
    // the word accepted while a skip or jump fires becomes a bubble
    take       = in_q4 && inst_valid && !skip_taken && !pc_load;
  end

  assign phase      = phase_q;
  assign d          = d_q;
  assign switch_a_m = sam_q;
  assign act_ram    = act_q;
  assign bit_number = bit_q;
  assign inst       = op_q;
  assign pc_target  = tgt_q;

  // Cycle-boundary capture: load a taken word, else start a bubble cycle
  always_comb begin
    op_d   = op_q;
    d_d    = d_q;
    sam_d  = sam_q;
    act_d  = act_q;
    wr_d   = wr_q;
    bit_d  = bit_q;
    skz_d  = skz_q;
    skc_d  = skc_q;
    sks_d  = sks_q;
    ctrl_d = ctrl_q;
    call_d = call_q;
    tgt_d  = tgt_q;
    if (in_q4) begin
      op_d   = ALU_OP_W'(OP_NOP);
      act_d  = 1'b0;
      wr_d   = 1'b0;
      skz_d  = 1'b0;
      skc_d  = 1'b0;
      sks_d  = 1'b0;
      ctrl_d = 1'b0;
      call_d = 1'b0;
      if (take) begin
        op_d   = dc_op;
        d_d    = dc_d;
        sam_d  = dc_sam;
        act_d  = dc_act;
        wr_d   = dc_wr;
        skz_d  = dc_skz;
        skc_d  = dc_skc;
        sks_d  = dc_sks;
        ctrl_d = dc_ctrl;
        call_d = dc_call;
        if (dc_is_bit) bit_d = dc_bit;
        if (dc_ctrl)   tgt_d = dc_tgt;
      end
    end
  end

  // Executing-cycle field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= ALU_OP_W'(OP_NOP);
      d_q    <= 1'b0;
      sam_q  <= 1'b0;
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      bit_q  <= '0;
      skz_q  <= 1'b0;
      skc_q  <= 1'b0;
      sks_q  <= 1'b0;
      ctrl_q <= 1'b0;
      call_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      op_q   <= op_d;
      d_q    <= d_d;
      sam_q  <= sam_d;
      act_q  <= act_d;
      wr_q   <= wr_d;
      bit_q  <= bit_d;
      skz_q  <= skz_d;
      skc_q  <= skc_d;
      sks_q  <= sks_d;
      ctrl_q <= ctrl_d;
      call_q <= call_d;
      tgt_q  <= tgt_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic ill_q, ill_d, illegal_q, illegal_d;

  // Illegal tracking: mark the executing word, latch sticky at end of Q4
  always_comb begin
    ill_d = ill_q;
    if (in_q4) ill_d = take && dc_illegal;
    illegal_d = illegal_q || (in_q4 && ill_q);
    illegal   = illegal_q || (in_q4 && ill_q);
  end

  // Illegal flag registers; cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ill_q     <= ill_d;
      illegal_q <= illegal_d;
    end
  end
`else
  logic ill_unused;
  assign ill_unused = dc_illegal;
  assign illegal    = 1'b0;
`endif

endmodule

// File: doc/decode_seq.md
Name: decode_seq

Overview:
- Registered, phase-sequenced instruction decoder; next generation of the 4-phase decode stage.
- Replaces the four external phase clocks with an internal Q1..Q4 phase counter on one clock.
- Accepts instructions from fetch via a valid/ready handshake. Adds skip instructions (DECFSZ/INCFSZ/BTFSC/BTFSS), GOTO/CALL, bubbles and squash.
- Sits between the instruction register/fetch and the ALU/alu_mux/RAM/PC logic.

Parameters:
- INST_W, 8, instruction width; must be >= 8; class = [INST_W-1:INST_W-2], sub-op = [INST_W-3:INST_W-6].
- BIT_W, 3, bit-number width; bit field = inst_reg[BIT_W:1].
- ALU_OP_W, 4, ALU operation code width.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- inst_valid, in, 1, fetch presents inst_reg.
- inst_ready, out, 1, high during Q4; the instruction is accepted when valid&&ready.
- inst_reg, in, INST_W, instruction word.
- alu_zero, in, 1, ALU result zero; sampled in Q4.
- bit_val, in, 1, tested RAM bit; sampled in Q4.
- phase, out, 2, current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
- d, out, 1, destination: 1=f, 0=w.
- switch_a_m, out, 1, alu_mux select: 1=f, 0=literal k.
- act_ram, out, 1, RAM access enable.
- write_en, out, 1, result write strobe.
- bit_number, out, BIT_W, bit index for bit operations.
- inst, out, ALU_OP_W, ALU operation code.
- skip_taken, out, 1, one-clock pulse in Q4 when a skip condition is met.
- pc_load, out, 1, one-clock pulse in Q4 for GOTO/CALL.
- push_en, out, 1, one-clock pulse in Q4 for CALL.
- pc_target, out, INST_W-3, jump target = inst_reg[INST_W-4:0].
- illegal, out, 1, sticky illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate, including mid-instruction):
  - phase=Q1, d=0, switch_a_m=0, act_ram=0, write_en=0, bit_number=0, inst=OP_NOP(1).
  - skip_taken, pc_load, push_en, pc_target and illegal = 0.
  - Decoder enters the bubble state. The first acceptance is possible at the first Q4 after reset.
- Phase counter: increments every clk and wraps Q4->Q1. One instruction cycle = 4 clks.
- Acceptance:
  - In Q4, if inst_valid is high, decode fields are registered on the Q4->Q1 edge and are stable for the whole next cycle.
  - If inst_valid is low in Q4, the next cycle is a bubble: act_ram=0, write_en=0, inst=OP_NOP. Other fields hold.
- Class 00 (byte ops): act_ram=1, d=inst_reg[1], switch_a_m=1. Sub-op map:
  - 0111 ADD; 0101 AND; 0001 CLR; 1001 COM; 0011 DEC; 1011 DECFSZ (DEC); 1010 INC; 1111 INCFSZ (INC).
  - 0100 IOR; 1000 MOVF; 0000 MOVWF/NOP; 1101 RLF; 1100 RRF; 0010 SUB; 1110 SWAP; 0110 XOR.
- Class 01 (bit ops): act_ram=1, d=1, switch_a_m=1, bit_number=inst_reg[BIT_W:1].
  - 00xx BCF; 01xx BSF.
  - 10xx BTFSC and 11xx BTFSS: inst=OP_NOP, no write.
- Class 11 (literal): act_ram=0, d=0, switch_a_m=0.
  - 00xx MOVLW; 1000 IOR; 1001 AND; 1010 XOR; 110x SUB; 111x ADD.
  - 01xx is illegal: decoded as OP_NOP.
- Class 10 (control): act_ram=0, inst=OP_NOP, no write. inst_reg[INST_W-3]=1 is GOTO, 0 is CALL.
  - pc_load pulses in Q4; push_en also pulses for CALL.
- write_en:
  - High in Q3 and Q4 of an executing cycle for writing ops: all class 00, BCF/BSF, and class 11 except illegal.
  - Low for bubbles, squashed cycles, BTFSx and class 10.
- Skip:
  - In Q4, skip_taken=1 for DECFSZ/INCFSZ with alu_zero=1, BTFSC with bit_val=0, or BTFSS with bit_val=1.
  - GOTO/CALL also squash the following instruction.
- Squash:
  - The instruction accepted in that same Q4 executes as a bubble: act_ram=0, write_en=0, no pulses, no skip evaluation.
  - A squashed instruction never raises skip_taken or pc_load, so there are no double skips.
- Simultaneous events:
  - If skip_taken and pc_load are both possible, only pc_load applies.
  - Acceptance still occurs in the squashing Q4 (ready is not lowered).

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode executing (not squashed) sets illegal=1 at Q4. The flag is sticky until rst_n. The op still decodes as OP_NOP with no write.
- Undefined: the illegal port is tied to 0 and illegal opcodes silently decode as NOP.

Decomposition:
- Package decode_pkg holds:
  - ALU op constants: OP_MOVF=0, OP_NOP=1, ADD=2, SUB=3, AND=4, INC=5, DEC=6, XOR=7, RLF=8, CLR=9, IOR=10, SWAP=11, COM=12, BSF=13, BCF=14, RRF=15.
  - Class encodings CLS_BYTE/CLS_BIT/CLS_CTRL/CLS_LIT.
  - Phase enum Q1..Q4.
- One sub-module, decode_comb: pure field decode of inst_reg.
- decode_seq holds the phase counter, handshake, squash and skip registers.

Test Plan:
- Reset mid-cycle: deassert rst_n at phase Q3 with write_en=1 -> write_en=0, phase=0 and inst=1 immediately, with no clk edge required.
- Accept ADDWF 8'b00011110 -> next cycle inst=2, d=1, act_ram=1, switch_a_m=1; write_en high only in Q3/Q4.
- DECFSZ 8'b00101110 with alu_zero=1 in Q4 -> skip_taken pulse. The following MOVLW 8'b11000101 runs with write_en=0 and act_ram=0.
- BTFSS 8'b01110110, bit_val=1, then GOTO 8'b10100011 -> the GOTO is squashed and pc_load is never raised. Repeat with bit_val=0 -> pc_load pulses with pc_target=5'b00011 and the next instruction is squashed.
- CALL 8'b10000111 -> pc_load=push_en=1 for one clk in Q4 and pc_target=7.
- inst_valid low at Q4 -> bubble cycle with inst=1. With DECODE_ILLEGAL_TRAP_EN, 8'b11010000 sets illegal=1 and it stays set.
